// File: rtl/ddfs_pkg.sv
// Shared constants and types for the DDFS frequency-hop scheduler.
package ddfs_pkg;

  localparam int unsigned FCW_W           = 10;
  localparam int unsigned DEPTH_DEFAULT   = 8;
  localparam int unsigned DWELL_W_DEFAULT = 16;
  localparam int unsigned SETTLE_DEFAULT  = 18;

  typedef logic [FCW_W-1:0] fcw_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/ddfs_hop_table.sv
// Hop table: one synchronous write port, one asynchronous read port,
// every entry cleared by reset.
module ddfs_hop_table
  import ddfs_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned DWELL_W = DWELL_W_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  fcw_t               wfcw_i,
  input  logic [DWELL_W-1:0] wdwell_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output fcw_t               rfcw_o,
  output logic [DWELL_W-1:0] rdwell_o
);

  fcw_t               fcw_q   [DEPTH];
  logic [DWELL_W-1:0] dwell_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        fcw_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else if (we_i) begin
      fcw_q[waddr_i]   <= wfcw_i;
      dwell_q[waddr_i] <= wdwell_i;
    end
  end

  assign rfcw_o   = fcw_q[raddr_i];
  assign rdwell_o = dwell_q[raddr_i];

endmodule

// File: rtl/ddfs_hop_scheduler.sv
// Steps a DDFS through a programmed list of (FCW, dwell) hops, masking
// wave_valid while the synthesiser pipeline settles after each FCW change.
module ddfs_hop_scheduler
  import ddfs_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned DWELL_W = DWELL_W_DEFAULT,
  parameter int unsigned SETTLE  = SETTLE_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned LEN_W  = IDX_W + 1
) (
  input  logic               clock_100_MHz,
  input  logic               clear_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [FCW_W-1:0]   cfg_fcw,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [LEN_W-1:0]   list_len,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  output logic [FCW_W-1:0]   FCW,
  output logic               clear_DDFS,
  output logic               wave_valid,
  output logic               busy,
  output logic               hop_strobe,
  output logic               done,
  output logic               cfg_err,
  output logic [IDX_W-1:0]   hop_index
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               loop_q, loop_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  fcw_t               fcw_q, fcw_d;
  logic               clr_q, clr_d, valid_q, valid_d, busy_q, busy_d;
  logic               strobe_q, strobe_d, done_q, done_d, err_q, err_d;
  logic               hop_c, bad_start_c;
  fcw_t               tbl_fcw;
  logic [DWELL_W-1:0] tbl_dwell;

  // Read address follows the next index so FCW lands in the same cycle as the hop.
  ddfs_hop_table #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) u_table (
    .clk_i    (clock_100_MHz),
    .rst_ni   (clear_n),
    .we_i     (cfg_we && !busy_q),
    .waddr_i  (cfg_addr),
    .wfcw_i   (cfg_fcw),
    .wdwell_i (cfg_dwell),
    .raddr_i  (idx_d),
    .rfcw_o   (tbl_fcw),
    .rdwell_o (tbl_dwell)
  );

  always_ff @(posedge clock_100_MHz or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      settle_q <= '0;
      dwell_q  <= '0;
      fcw_q    <= '0;
      clr_q    <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      fcw_q    <= fcw_d;
      clr_q    <= clr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Sequencing; stop outranks everything once a run is underway.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    loop_d      = loop_q;
    settle_d    = settle_q;
    dwell_d     = dwell_q;
    hop_c       = 1'b0;
    bad_start_c = 1'b0;
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            if ((list_len == '0) || (list_len > LEN_W'(DEPTH))) begin
              bad_start_c = 1'b1;
            end else begin
              state_d = ST_FLUSH;
              idx_d   = '0;
              len_d   = list_len;
              loop_d  = loop_en;
            end
          end
        end
        ST_FLUSH: begin
          state_d  = ST_SETTLE;
          settle_d = SET_W'(SETTLE);
        end
        ST_SETTLE: begin
          if (settle_q <= SET_W'(1)) begin
            state_d = ST_DWELL;
            dwell_d = (tbl_dwell == '0) ? DWELL_W'(1) : tbl_dwell;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        ST_DWELL: begin
          if (dwell_q <= DWELL_W'(1)) begin
            if ((LEN_W'(idx_q) + LEN_W'(1)) < len_q) begin
              hop_c = 1'b1;
              idx_d = idx_q + IDX_W'(1);
            end else if (loop_q) begin
              hop_c = 1'b1;
              idx_d = '0;
            end
            if (hop_c) begin
              state_d  = ST_SETTLE;
              settle_d = SET_W'(SETTLE);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the state being entered, registered alongside it.
  always_comb begin
    fcw_d    = '0;
    clr_d    = 1'b1;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    strobe_d = hop_c;
    err_d    = bad_start_c || (cfg_we && busy_q);
    unique case (state_d)
      ST_FLUSH: begin
        fcw_d  = tbl_fcw;
        busy_d = 1'b1;
      end
      ST_SETTLE: begin
        fcw_d  = tbl_fcw;
        clr_d  = 1'b0;
        busy_d = 1'b1;
      end
      ST_DWELL: begin
        fcw_d   = tbl_fcw;
        clr_d   = 1'b0;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
  end

  assign FCW        = fcw_q;
  assign clear_DDFS = clr_q;
  assign wave_valid = valid_q;
  assign busy       = busy_q;
  assign hop_strobe = strobe_q;
  assign done       = done_q;
  assign cfg_err    = err_q;
  assign hop_index  = idx_q;

endmodule

// File: doc/ddfs_hop_scheduler.md
DDFS_HOP_SCHEDULER -- requirements
Module: ddfs_hop_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, hop-table entry count (power of two).
REQ-002 SHALL have parameter DWELL_W, default 16, dwell-counter width.
REQ-003 SHALL have parameter SETTLE, default 18, DDFS FCW-to-output latency in cycles.
REQ-004 SHALL have port clock_100_MHz, input, 1, sole clock, all logic rising-edge.
REQ-005 SHALL have port clear_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_we, input, 1, table write strobe.
REQ-007 SHALL have port cfg_addr, input, log2(DEPTH), table write address.
REQ-008 SHALL have port cfg_fcw, input, 10, FCW value for the entry.
REQ-009 SHALL have port cfg_dwell, input, DWELL_W, dwell cycles for the entry.
REQ-010 SHALL have port list_len, input, log2(DEPTH)+1, number of active entries, sampled at start.
REQ-011 SHALL have port loop_en, input, 1, wrap to entry 0 after last entry, sampled at start.
REQ-012 SHALL have ports start and stop, input, 1 each, single-cycle command pulses.
REQ-013 SHALL have port FCW, output, 10, drives the DDFS frequency control word.
REQ-014 SHALL have port clear_DDFS, output, 1, active-high synchronous clear to the DDFS.
REQ-015 SHALL have ports wave_valid, busy, hop_strobe, done, cfg_err, output, 1 each.
REQ-016 SHALL have port hop_index, output, log2(DEPTH), entry currently driving FCW.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH, SETTLE, DWELL, DONE.
REQ-018 IDLE: FCW=0, clear_DDFS=1, busy=0; on start with 1<=list_len<=DEPTH, latch list_len/loop_en, load hop_index=0, go to FLUSH.
REQ-019 FLUSH: exactly 1 cycle, clear_DDFS=1, FCW=table[0].fcw, busy=1; then SETTLE.
REQ-020 SETTLE: clear_DDFS=0, wave_valid=0, count SETTLE cycles, then DWELL.
REQ-021 DWELL: wave_valid=1 for exactly max(dwell,1) cycles; dwell=0 is treated as 1.
REQ-022 At end of DWELL, if hop_index<list_len-1: hop_index+1, FCW updated the next cycle, hop_strobe pulses 1 cycle, go to SETTLE (no clear; phase continuous).
REQ-023 At end of DWELL on last entry: loop_en=1 wraps to hop_index 0 with hop_strobe; otherwise go to DONE.
REQ-024 DONE: done=1 for 1 cycle, clear_DDFS=1, busy=0, then IDLE.
REQ-025 Start latency: first wave_valid=1 exactly 1+SETTLE cycles after the FLUSH cycle.
REQ-026 stop in any non-IDLE state: next cycle IDLE, wave_valid=0, clear_DDFS=1, done not asserted.
REQ-027 start and stop in the same cycle: stop wins; in IDLE both are a no-op.
REQ-028 start while busy SHALL be ignored without error.
REQ-029 start with list_len=0 or list_len>DEPTH: stay IDLE, cfg_err pulses 1 cycle.
REQ-030 cfg_we while busy: write dropped, cfg_err pulses 1 cycle; in IDLE, write takes effect the next cycle.
REQ-031 Dwell counter SHALL not overflow: counts down from the loaded value, and a load of 0 is clamped to 1.

Reset
REQ-032 clear_n low SHALL asynchronously force IDLE, FCW=0, clear_DDFS=1, wave_valid=0, busy=0, hop_strobe=0, done=0, cfg_err=0, hop_index=0, and all counters 0.
REQ-033 Table contents SHALL reset to fcw=0, dwell=0.
REQ-034 Reset asserted mid-run SHALL abort with no done pulse; after release the block SHALL stay IDLE until a new start.

Structure
REQ-035 Package ddfs_pkg SHALL hold FCW_W=10, DEPTH default, SETTLE default, and the FSM state enum.
REQ-036 Table storage SHALL be a sub-module ddfs_hop_table with 1 write port, 1 asynchronous read port, and async reset.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 Program entries {fcw 5/dwell 4, fcw 9/dwell 2}, list_len=2, loop_en=0, start -> clear_DDFS 1 cycle; wave_valid high 4 cycles at FCW=5, then after 18 low cycles high 2 cycles at FCW=9; done pulses once.
REQ-039 Same program with loop_en=1 -> hop_index sequence 0,1,0,1...; hop_strobe once per hop; done never asserted.
REQ-040 stop 3 cycles into DWELL -> next cycle IDLE, clear_DDFS=1, wave_valid=0, no done.
REQ-041 list_len=0 start -> cfg_err 1 pulse, busy stays 0; cfg_we during busy -> cfg_err, table unchanged on readback run.
REQ-042 dwell=0 entry -> wave_valid high exactly 1 cycle.
REQ-043 clear_n low mid-SETTLE -> all outputs at reset values immediately; start after release -> normal sequence from entry 0.
